// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants
package seg7_pkg;

  // Active-low gfedcba patterns for hex digits 0..F, identical to the encoder table
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         SEG_DP_BIT = 7;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational 7-segment pattern to nibble decoder
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       hit,
  output logic       blank
);

  // Search the hex table; patterns are unique so at most one entry matches
  always_comb begin
    nibble = 4'h0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_HEX[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
    blank = (pattern == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed 7-segment bus monitor and decoder
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     an_in,
  input  logic                      err_clr,
  output logic [4*NUM_DIGITS-1:0]   digit_val,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic [NUM_DIGITS-1:0]     dp_out,
  output logic                      upd_strobe,
  output logic [1:0]                upd_idx,
  output logic                      err
);

  localparam int         SW      = NUM_DIGITS + 8;
  localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]           sync1_q, sync1_d, s_q, s_d, s_prev_q, s_prev_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    armed_q, armed_d;
  logic                    commit;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, dp_q, dp_d;
  logic                    strobe_q, strobe_d;
  logic [1:0]              idx_q, idx_d;
  logic                    err_q, err_d;

  logic [NUM_DIGITS-1:0]   an_s;
  logic [2:0]              n_low;
  logic [1:0]              sel;
  logic                    set_err;
  logic [3:0]              dec_nibble;
  logic                    dec_hit, dec_blank;

  assign an_s = s_q[SW-1:8];

  seg7_pattern_decode u_decode (
    .pattern (s_q[6:0]),
    .nibble  (dec_nibble),
    .hit     (dec_hit),
    .blank   (dec_blank)
  );

  // Synchroniser and stability filter: one commit per run of identical samples
  always_comb begin
    sync1_d  = {an_in, seg_in};
    s_d      = sync1_q;
    s_prev_d = s_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    commit   = 1'b0;
    if (s_q != s_prev_q) begin
      cnt_d   = 8'd1;
      armed_d = 1'b1;
    end else begin
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      if (armed_q && cnt_q == CNT_HIT) begin
        commit  = 1'b1;
        armed_d = 1'b0;
      end
    end
  end

  // Classify the committed sample and update only the selected digit slot
  always_comb begin
    val_d    = val_q;
    valid_d  = valid_q;
    dp_d     = dp_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    set_err  = 1'b0;
    n_low    = 3'd0;
    sel      = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) begin
        n_low = n_low + 3'd1;
        sel   = 2'(i);
      end
    end
    if (commit && n_low != 3'd0) begin
      if (n_low > 3'd1) begin
        set_err = 1'b1;
      end else begin
        strobe_d    = 1'b1;
        idx_d       = sel;
        dp_d[sel]   = ~s_q[SEG_DP_BIT];
        if (dec_hit) begin
          val_d[4*sel +: 4] = dec_nibble;
          valid_d[sel]      = 1'b1;
        end else begin
          valid_d[sel] = 1'b0;
          if (!dec_blank) set_err = 1'b1;
        end
      end
    end
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (set_err) err_d = 1'b1;
  end

  // State registers; everything clears on reset, including the filter window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      s_q      <= '0;
      s_prev_q <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      val_q    <= '0;
      valid_q  <= '0;
      dp_q     <= '0;
      strobe_q <= 1'b0;
      idx_q    <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      s_q      <= s_d;
      s_prev_q <= s_prev_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      val_q    <= val_d;
      valid_q  <= valid_d;
      dp_q     <= dp_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  assign digit_val   = val_q;
  assign digit_valid = valid_q;
  assign dp_out      = dp_q;
  assign upd_strobe  = strobe_q;
  assign upd_idx     = idx_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_in = 8'hFF;
  logic [3:0]  an_in = 4'hF;
  logic        err_clr = 1'b0;
  logic [15:0] digit_val;
  logic [3:0]  digit_valid;
  logic [3:0]  dp_out;
  logic        upd_strobe;
  logic [1:0]  upd_idx;
  logic        err;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int base;
  logic [7:0] idx_hist = 8'h00;

  seg7_scan_decoder #(.STABLE_CYCLES(4), .NUM_DIGITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .err_clr     (err_clr),
    .digit_val   (digit_val),
    .digit_valid (digit_valid),
    .dp_out      (dp_out),
    .upd_strobe  (upd_strobe),
    .upd_idx     (upd_idx),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Strobe monitor: count pulses and keep a history of committed indices
  always @(negedge clk) begin
    if (upd_strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      idx_hist   = {idx_hist[5:0], upd_idx};
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic show(input logic [3:0] an, input logic [7:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    tick(n);
  endtask

  function automatic logic [31:0] all_out();
    return {4'h0, digit_val, digit_valid, dp_out, upd_strobe, upd_idx, err};
  endfunction

  initial begin
    // 1: reset holds everything at zero despite toggling inputs
    for (int i = 0; i < 6; i++) begin
      seg_in = 8'($urandom);
      an_in  = 4'($urandom);
      tick(1);
    end
    chk("reset_outputs", all_out(), 32'h0);
    show(4'hF, 8'hFF, 2);
    rst_n = 1'b1;
    base = strobe_cnt;
    tick(10);
    chk("blank_after_reset", all_out(), 32'h0);
    chk("blank_no_strobe", 32'(strobe_cnt - base), 32'd0);

    // 2: single digit, exact commit latency
    base = strobe_cnt;
    show(4'b0111, 8'b1010_0100, 5);
    chk("lat_early_strobe", {31'd0, upd_strobe}, 32'd1 - 32'd1);
    tick(1);
    chk("lat_strobe", {31'd0, upd_strobe}, 32'd1);
    chk("lat_idx", {30'd0, upd_idx}, 32'd3);
    chk("lat_val", {28'd0, digit_val[15:12]}, 32'h2);
    chk("lat_valid", {28'd0, digit_valid}, 32'b1000);
    chk("lat_dp", {28'd0, dp_out}, 32'h0);
    tick(1);
    chk("lat_strobe_drop", {31'd0, upd_strobe}, 32'd0);
    tick(8);
    chk("lat_one_strobe", 32'(strobe_cnt - base), 32'd1);

    // 3: full scan of four digits
    base = strobe_cnt;
    show(4'b1110, 8'hF9, 8);
    show(4'b1101, 8'h08, 8);
    show(4'b1011, 8'hC6, 8);
    show(4'b0111, 8'h8E, 8);
    chk("scan_val", {16'd0, digit_val}, 32'hFCA1);
    chk("scan_valid", {28'd0, digit_valid}, 32'hF);
    chk("scan_dp", {28'd0, dp_out}, 32'b0010);
    chk("scan_strobes", 32'(strobe_cnt - base), 32'd4);
    chk("scan_idx_order", {24'd0, idx_hist}, 32'h1B);

    // 4: short glitch window never commits
    base = strobe_cnt;
    show(4'b1110, 8'hC0, 3);
    show(4'b1111, 8'hFF, 10);
    chk("glitch_no_strobe", 32'(strobe_cnt - base), 32'd0);
    chk("glitch_val", {16'd0, digit_val}, 32'hFCA1);
    chk("glitch_valid", {28'd0, digit_valid}, 32'hF);

    // blank pattern with DP lit: invalidates digit 3 without error
    base = strobe_cnt;
    show(4'b0111, 8'h7F, 8);
    chk("blank_valid", {28'd0, digit_valid}, 32'b0111);
    chk("blank_val", {16'd0, digit_val}, 32'hFCA1);
    chk("blank_dp", {28'd0, dp_out}, 32'b1010);
    chk("blank_err", {31'd0, err}, 32'd0);
    chk("blank_strobe", 32'(strobe_cnt - base), 32'd1);

    // 5: invalid pattern sets err, clear, then clear coincident with a new set
    base = strobe_cnt;
    show(4'b1110, 8'hF7, 8);
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_valid", {28'd0, digit_valid}, 32'b0110);
    chk("bad_strobe", 32'(strobe_cnt - base), 32'd1);
    chk("bad_idx", {30'd0, upd_idx}, 32'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);
    show(4'b1101, 8'h77, 5);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("set_wins_err", {31'd0, err}, 32'd1);
    chk("set_wins_strobe", {31'd0, upd_strobe}, 32'd1);
    chk("set_wins_idx", {30'd0, upd_idx}, 32'd1);
    chk("set_wins_valid", {28'd0, digit_valid}, 32'b0100);
    tick(4);

    // 6: ambiguous anodes, then reset mid-window
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("pre_amb_err", {31'd0, err}, 32'd0);
    base = strobe_cnt;
    show(4'b0011, 8'hC0, 10);
    chk("amb_err", {31'd0, err}, 32'd1);
    chk("amb_no_strobe", 32'(strobe_cnt - base), 32'd0);
    chk("amb_val", {16'd0, digit_val}, 32'hFCA1);
    chk("amb_valid", {28'd0, digit_valid}, 32'b0100);
    show(4'b1110, 8'hC0, 2);
    rst_n = 1'b0;
    #1;
    chk("async_reset", all_out(), 32'h0);
    tick(2);
    show(4'b1111, 8'hFF, 1);
    rst_n = 1'b1;
    base = strobe_cnt;
    tick(10);
    chk("post_reset_outputs", all_out(), 32'h0);
    chk("post_reset_no_strobe", 32'(strobe_cnt - base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
